// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer swap controller.
package fb_pkg;

  localparam int FB_W      = 640;
  localparam int FB_H      = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DROP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DRAW,
    WAIT_SWAP,
    SWAP
  } fb_state_t;

  typedef logic [7:0] pixel_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Registers a committed engine pixel into a linear frame-buffer write cycle.
// Defining FB_CLIP_EN suppresses writes whose coordinate falls outside W x H.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int W      = FB_W,
  parameter int H      = FB_H,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall_i,
  input  logic              commit_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  pixel_t            color_i,
  input  logic              sel_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output pixel_t            wdata_o,
  output logic              sel_o
);

`ifdef FB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic              in_range;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  pixel_t            data_q;
  logic              sel_q;

  assign in_range = !CLIP_EN || ((int'(x_i) < W) && (int'(y_i) < H));
  assign addr_d   = ADDR_W'(y_i) * ADDR_W'(W) + ADDR_W'(x_i);

  // A write presented while the port is stalled stays held until it drains.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (Reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= commit_i && in_range;
      if (commit_i) begin
        addr_q <= addr_d;
        data_q <= color_i;
        sel_q  <= sel_i;
      end
    end
  end

  assign we_o    = valid_q && !stall_i;
  assign waddr_o = addr_q;
  assign wdata_o = data_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/fb_swap_controller.sv
// Per-frame draw sequencing and tear-free double-buffer swap in vertical blank.
// Optional FB_CLIP_EN (in fb_addr_gen) drops off-screen writes.
module fb_swap_controller
  import fb_pkg::*;
#(
  parameter int W      = FB_W,
  parameter int H      = FB_H,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DROP_W = FB_DROP_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vblank,
  input  logic              fb_busy,
  input  logic              draw_done,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  pixel_t            draw_color,
  output logic              draw_start,
  output logic              wr_en,
  output logic              buffer_using,
  output logic              display_sel,
  output logic              fb_we,
  output logic              fb_sel,
  output logic [ADDR_W-1:0] fb_waddr,
  output pixel_t            fb_wdata,
  output logic [DROP_W-1:0] frames_dropped
);

  fb_state_t         state_q;
  logic              vblank_q;
  logic              vblank_rise;
  logic              draw_start_q;
  logic              buffer_using_q;
  logic [DROP_W-1:0] drops_q;

  assign vblank_rise = vblank && !vblank_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      vblank_q       <= 1'b0;
      draw_start_q   <= 1'b0;
      buffer_using_q <= 1'b1;
      drops_q        <= '0;
    end else begin
      vblank_q     <= vblank;
      draw_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (vblank_rise) begin
            state_q      <= START;
            draw_start_q <= 1'b1;
          end
        end
        START: state_q <= DRAW;
        DRAW: begin
          // Completion wins over a coincident blank: the frame is not dropped.
          if (draw_done) begin
            state_q <= WAIT_SWAP;
          end else if (vblank_rise && (drops_q != '1)) begin
            drops_q <= drops_q + DROP_W'(1);
          end
        end
        WAIT_SWAP: begin
          if (vblank_rise) begin
            state_q        <= SWAP;
            buffer_using_q <= ~buffer_using_q;
          end
        end
        SWAP: begin
          state_q      <= START;
          draw_start_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en          = (state_q == DRAW) && !fb_busy && !Reset;
  assign draw_start     = draw_start_q;
  assign buffer_using   = buffer_using_q;
  assign display_sel    = ~buffer_using_q;
  assign frames_dropped = drops_q;

  fb_addr_gen #(
    .W      (W),
    .H      (H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .Clk      (Clk),
    .Reset    (Reset),
    .stall_i  (fb_busy),
    .commit_i (wr_en),
    .x_i      (draw_x),
    .y_i      (draw_y),
    .color_i  (draw_color),
    .sel_i    (buffer_using_q),
    .we_o     (fb_we),
    .waddr_o  (fb_waddr),
    .wdata_o  (fb_wdata),
    .sel_o    (fb_sel)
  );

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller; the DUT uses a 2-bit drop counter
// so saturation is reachable in a few frames.
module tb_fb_swap_controller;
  import fb_pkg::*;

  localparam int DW = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              vblank = 1'b0;
  logic              fb_busy = 1'b0;
  logic              draw_done = 1'b0;
  logic [9:0]        draw_x = '0;
  logic [9:0]        draw_y = '0;
  pixel_t            draw_color = '0;
  logic              draw_start;
  logic              wr_en;
  logic              buffer_using;
  logic              display_sel;
  logic              fb_we;
  logic              fb_sel;
  logic [FB_ADDR_W-1:0] fb_waddr;
  pixel_t            fb_wdata;
  logic [DW-1:0]     frames_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  fb_swap_controller #(
    .W      (FB_W),
    .H      (FB_H),
    .ADDR_W (FB_ADDR_W),
    .DROP_W (DW)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .vblank         (vblank),
    .fb_busy        (fb_busy),
    .draw_done      (draw_done),
    .draw_x         (draw_x),
    .draw_y         (draw_y),
    .draw_color     (draw_color),
    .draw_start     (draw_start),
    .wr_en          (wr_en),
    .buffer_using   (buffer_using),
    .display_sel    (display_sel),
    .fb_we          (fb_we),
    .fb_sel         (fb_sel),
    .fb_waddr       (fb_waddr),
    .fb_wdata       (fb_wdata),
    .frames_dropped (frames_dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic px(input int x, input int y, input int c);
    draw_x     = 10'(x);
    draw_y     = 10'(y);
    draw_color = 8'(c);
  endtask

  task automatic vpulse();
    cyc();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    Reset = 1'b0;
    mid();
    check("rst_draw_start", 32'(draw_start), 0);
    check("rst_buffer_using", 32'(buffer_using), 1);
    check("rst_display_sel", 32'(display_sel), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_dropped", 32'(frames_dropped), 0);
    check("rst_waddr", 32'(fb_waddr), 0);

    // First blank starts a pass one cycle after the rise
    cyc(); vblank = 1'b1; mid();
    check("start_not_yet", 32'(draw_start), 0);
    cyc(); mid();
    check("start_pulse", 32'(draw_start), 1);
    check("start_buf", 32'(buffer_using), 1);
    check("start_disp", 32'(display_sel), 0);
    cyc(); vblank = 1'b0; px(5, 2, 'h46); mid();
    check("start_one_cycle", 32'(draw_start), 0);
    check("draw_wr_en", 32'(wr_en), 1);

    // Basic write: (5,2) -> 2*640+5
    cyc(); px(7, 3, 'h11); mid();
    check("wr1_we", 32'(fb_we), 1);
    check("wr1_addr", 32'(fb_waddr), 1285);
    check("wr1_data", 32'(fb_wdata), 'h46);
    check("wr1_sel", 32'(fb_sel), 1);

    // Three stalled cycles: no grant, no strobe; held write drains on release
    cyc(); fb_busy = 1'b1; px(9, 0, 'h99); mid();
    check("busy1_wr_en", 32'(wr_en), 0);
    check("busy1_we", 32'(fb_we), 0);
    cyc(); mid();
    check("busy2_wr_en", 32'(wr_en), 0);
    check("busy2_we", 32'(fb_we), 0);
    cyc(); mid();
    check("busy3_wr_en", 32'(wr_en), 0);
    check("busy3_we", 32'(fb_we), 0);
    cyc(); fb_busy = 1'b0; px(1, 1, 'h22); mid();
    check("rel_wr_en", 32'(wr_en), 1);
    check("rel_held_we", 32'(fb_we), 1);
    check("rel_held_addr", 32'(fb_waddr), 1927);
    check("rel_held_data", 32'(fb_wdata), 'h11);
    cyc(); px(640, 10, 'h33); mid();
    check("rel_next_we", 32'(fb_we), 1);
    check("rel_next_addr", 32'(fb_waddr), 641);
    check("rel_next_data", 32'(fb_wdata), 'h22);

    // Off-screen pixel (640,10)
    cyc(); px(0, 0, 0); mid();
`ifdef FB_CLIP_EN
    check("clip_we", 32'(fb_we), 0);
`else
    check("noclip_we", 32'(fb_we), 1);
    check("noclip_addr", 32'(fb_waddr), 7040);
`endif

    // Overruns: blank while still drawing
    vpulse(); mid();
    check("drop1", 32'(frames_dropped), 1);
    vpulse(); mid();
    check("drop2", 32'(frames_dropped), 2);
    check("drop2_buf", 32'(buffer_using), 1);
    check("drop2_disp", 32'(display_sel), 0);
    check("drop2_still_draw", 32'(wr_en), 1);
    vpulse(); vpulse(); vpulse(); mid();
    check("drop_sat", 32'(frames_dropped), 3);

    // Pass completes; the done cycle still commits
    cyc(); draw_done = 1'b1; px(4, 0, 'h44); mid();
    check("done_wr_en", 32'(wr_en), 1);
    cyc(); draw_done = 1'b0; mid();
    check("wait_wr_en", 32'(wr_en), 0);
    check("done_we", 32'(fb_we), 1);
    check("done_addr", 32'(fb_waddr), 4);

    // Swap at next blank, new pass immediately after
    cyc(); vblank = 1'b1; mid();
    check("preswap_buf", 32'(buffer_using), 1);
    cyc(); vblank = 1'b0; mid();
    check("swap_disp", 32'(display_sel), 1);
    check("swap_buf", 32'(buffer_using), 0);
    check("swap_no_start", 32'(draw_start), 0);
    cyc(); mid();
    check("swap_start", 32'(draw_start), 1);
    cyc(); px(2, 0, 'h55); mid();
    check("pass2_start_low", 32'(draw_start), 0);
    check("pass2_wr_en", 32'(wr_en), 1);

    // Done and blank rise together: counts as done, no drop, no swap yet
    cyc(); draw_done = 1'b1; vblank = 1'b1; mid();
    check("pass2_we", 32'(fb_we), 1);
    check("pass2_sel", 32'(fb_sel), 0);
    check("pass2_addr", 32'(fb_waddr), 2);
    check("pass2_data", 32'(fb_wdata), 'h55);
    cyc(); draw_done = 1'b0; vblank = 1'b0; mid();
    check("simul_wait", 32'(wr_en), 0);
    check("simul_no_swap", 32'(buffer_using), 0);
    check("simul_dropped", 32'(frames_dropped), 3);
    cyc(); vblank = 1'b1; mid();
    cyc(); vblank = 1'b0; mid();
    check("swap2_buf", 32'(buffer_using), 1);
    check("swap2_disp", 32'(display_sel), 0);
    cyc(); mid();
    check("swap2_start", 32'(draw_start), 1);
    cyc(); px(3, 0, 'h77); mid();
    check("pass3_wr_en", 32'(wr_en), 1);

    // Reset mid-pass
    cyc(); Reset = 1'b1; mid();
    check("rst_mid_wr_en", 32'(wr_en), 0);
    cyc(); Reset = 1'b0; mid();
    check("post_rst_wr_en", 32'(wr_en), 0);
    check("post_rst_we", 32'(fb_we), 0);
    check("post_rst_dropped", 32'(frames_dropped), 0);
    check("post_rst_buf", 32'(buffer_using), 1);
    cyc(); mid();
    check("post_rst_idle_start", 32'(draw_start), 0);
    check("post_rst_idle_we", 32'(fb_we), 0);
    check("post_rst_idle_wr_en", 32'(wr_en), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
